key_debouncer: RTL and testbench

- Multi-key input conditioner placed directly upstream of the per-key press edge detector.
- Takes raw, asynchronous, bouncy active-low board KEY pins and produces clean, synchronous, active-high "held" levels.
- The downstream edge detector converts each level into a single-cycle press pulse.
- Each lane has a two-flop synchronizer followed by a stability-counter FSM.

---
 rtl/key_debounce_pkg.sv | 5 +
 rtl/key_debounce_lane.sv | 53 +++++
 rtl/key_debouncer.sv | 23 ++
 tb/tb_key_debouncer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared state encoding and default settle time for the key debouncer
package key_debounce_pkg;
    typedef enum logic [1:0] {IDLE, ARM_PRESS, HELD, ARM_RELEASE} deb_state_t;
    localparam int DEFAULT_STABLE_CYCLES = 50000;
endpackage

// File: rtl/key_debounce_lane.sv
// key_debounce_lane: two-flop synchronizer plus stability-counter FSM for one active-low key
module key_debounce_lane
    import key_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_clean
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    logic             sync1_q, sync2_q;
    logic             s;
    logic             last;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign s    = ~sync2_q;
    assign last = (cnt_q == CNT_LAST);
    // The counter only runs while arming; every state change drops it back to zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE:        state_d = s ? ARM_PRESS : IDLE;
            ARM_PRESS: begin
                state_d = !s ? IDLE : (last ? HELD : ARM_PRESS);
                cnt_d   = (s && !last) ? cnt_q + 1'b1 : '0;
            end
            HELD:        state_d = s ? HELD : ARM_RELEASE;
            ARM_RELEASE: begin
                state_d = s ? HELD : (last ? IDLE : ARM_RELEASE);
                cnt_d   = (!s && !last) ? cnt_q + 1'b1 : '0;
            end
            default:     state_d = IDLE;
        endcase
    end
    assign key_clean = (state_q == HELD) || (state_q == ARM_RELEASE);
endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: NUM_KEYS independent debounce lanes turning bouncy active-low keys into clean held levels
module key_debouncer
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS      = 4,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_clean,
    output logic                any_held
);
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
        key_debounce_lane #(.STABLE_CYCLES(STABLE_CYCLES)) u_lane (
            .clk       (clk),
            .reset     (reset),
            .key_n     (key_n[g]),
            .key_clean (key_clean[g])
        );
    end
    assign any_held = |key_clean;
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed scenarios plus random bouncing keys against a run-length reference model
module tb_key_debouncer;
    localparam int NK = 4;
    localparam int SC = 4;
    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_clean;
    logic          any_held;
    int            vec_cnt = 0;
    int            err_cnt = 0;
    logic [NK-1:0] m_clean = '0;
    int            run[NK];
    logic [NK-1:0] hist[$];
    int            hold[NK];

    always #50 clk = ~clk;

    key_debouncer #(.NUM_KEYS(NK), .STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_n     (key_n),
        .key_clean (key_clean),
        .any_held  (any_held)
    );

    task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got %b, want %b", tag, $time, obs, exp);
        end
    endtask

    // Reference: the FSM sees each raw sample two edges later; a lane flips once the
    // pressed view has disagreed with the clean level on SC+1 consecutive edges.
    initial begin
        hist = '{'1, '1};
        foreach (run[i]) run[i] = 0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_clean = '0;
                hist = '{'1, '1};
                foreach (run[i]) run[i] = 0;
            end else begin
                logic [NK-1:0] s;
                s = ~hist[0];
                hist.push_back(key_n);
                void'(hist.pop_front());
                for (int i = 0; i < NK; i++) begin
                    run[i] = (s[i] != m_clean[i]) ? run[i] + 1 : 0;
                    if (run[i] == SC + 1) begin
                        m_clean[i] = ~m_clean[i];
                        run[i] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_clean", key_clean, m_clean);
        chk("model_any", any_held, |m_clean);
    end

    initial begin
        reset = 1'b0;
        key_n = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_clean", key_clean, '0);
            chk("rst_any", any_held, '0);
        end
        #5 reset = 1'b1;
        for (int e = 1; e <= SC + 3; e++) begin
            @(posedge clk); #1;
            chk("rst_lat", key_clean[0], e >= SC + 3);
        end
        @(negedge clk); key_n = '1;
        repeat (12) @(negedge clk);
        key_n = 4'b1110;
        for (int e = 1; e <= SC + 3; e++) begin
            @(posedge clk); #1;
            chk("press_k0", key_clean[0], e >= SC + 3);
            chk("press_any", any_held, e >= SC + 3);
            chk("press_others", key_clean[3:1], '0);
        end
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            key_n[1] = p[0];
            repeat ((p == 1) ? 1 : (p == 3) ? 10 : 3) begin
                @(negedge clk);
                chk("bounce_k1", key_clean[1], 1'b0);
            end
        end
        key_n[0] = 1'b1;
        repeat (2) begin @(negedge clk); chk("glitch_k0", key_clean[0], 1'b1); end
        key_n[0] = 1'b0;
        @(negedge clk); chk("glitch_k0", key_clean[0], 1'b1);
        key_n[0] = 1'b1;
        for (int e = 1; e <= SC + 3; e++) begin
            @(posedge clk); #1;
            chk("release_k0", key_clean[0], e < SC + 3);
        end
        @(negedge clk); key_n[3:2] = 2'b00;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            chk("simul_k2", key_clean[2], e >= SC + 3);
            chk("simul_k3", key_clean[3], e >= SC + 3 && e < SC + 13);
            if (e == 10) key_n[3] = 1'b1;
        end
        @(negedge clk); key_n[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_reset_k0", key_clean[0], 1'b1);
        #5 reset = 1'b0;
        #1 chk("async_clean", key_clean, '0);
        chk("async_any", any_held, '0);
        @(negedge clk); #5 reset = 1'b1;
        for (int e = 1; e <= SC + 3; e++) begin
            @(posedge clk); #1;
            chk("requalify_k0", key_clean[0], e >= SC + 3);
        end
        @(negedge clk); key_n = '1;
        repeat (12) @(negedge clk);
        foreach (hold[i]) hold[i] = 0;
        repeat (800) begin
            @(negedge clk);
            for (int i = 0; i < NK; i++) begin
                if (hold[i] == 0) begin
                    key_n[i] = ~key_n[i];
                    hold[i] = $urandom_range(1, 8);
                end else hold[i]--;
            end
            if ($urandom_range(0, 199) == 0) begin
                #5 reset = 1'b0;
                @(negedge clk); #5 reset = 1'b1;
            end
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
